// File: rtl/scie_pkg.sv
// rtl/scie_pkg.sv - shared types and opcodes for the SCIE complex FIR accelerator
package scie_pkg;

  localparam int NTAPS = 5;
  localparam int W     = 16;
  localparam int PW    = 32;
  // Five 32-bit products need three guard bits to sum without overflow.
  localparam int ACC_W = 35;

  localparam logic [6:0] OP_SETC = 7'h0B;
  localparam logic [6:0] OP_PUSH = 7'h2B;
  localparam logic [6:0] OP_READ = 7'h5B;

  typedef struct packed {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
  } cplx_t;

  typedef struct packed {
    logic signed [PW-1:0] re;
    logic signed [PW-1:0] im;
  } cprod_t;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PW-1:0] v);
    return {{(ACC_W-PW){v[PW-1]}}, v};
  endfunction

endpackage

// File: rtl/scie_cmul.sv
// rtl/scie_cmul.sv - combinational complex multiply, 16-bit operands to 32-bit products
module scie_cmul
  import scie_pkg::*;
(
  input  cplx_t  a,
  input  cplx_t  b,
  output cprod_t p
);

  logic signed [PW-1:0] rr;
  logic signed [PW-1:0] ii;
  logic signed [PW-1:0] ri;
  logic signed [PW-1:0] ir;

  assign rr = $signed(a.re) * $signed(b.re);
  assign ii = $signed(a.im) * $signed(b.im);
  assign ri = $signed(a.re) * $signed(b.im);
  assign ir = $signed(a.im) * $signed(b.re);

  assign p.re = rr - ii;
  assign p.im = ri + ir;

endmodule

// File: rtl/scie_pipelined.sv
// rtl/scie_pipelined.sv - pipelined 5-tap complex FIR behind a custom-instruction port
module scie_pipelined
  import scie_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                io_valid,
  input  logic [31:0]         io_insn,
  input  logic signed [W-1:0] io_rs1_real,
  input  logic signed [W-1:0] io_rs1_imag,
  input  logic [31:0]         io_rs2,
  output logic signed [W-1:0] io_rd_real,
  output logic signed [W-1:0] io_rd_imag
);

  logic [6:0] opcode;
  logic       do_setc;
  logic       do_push;
  logic       do_read;
  logic [2:0] coef_idx;
  cplx_t      rs1;

  cplx_t  coef      [NTAPS];
  cplx_t  samp      [NTAPS];
  cprod_t prod_next [NTAPS];
  cprod_t prod      [NTAPS];

  logic signed [ACC_W-1:0] sum_re;
  logic signed [ACC_W-1:0] sum_im;

  // Only the opcode and the low index bits carry meaning.
  logic unused_bits;
  assign unused_bits = ^{io_insn[31:7], io_rs2[31:3]};

  assign opcode   = io_insn[6:0];
  assign do_setc  = io_valid && (opcode == OP_SETC);
  assign do_push  = io_valid && (opcode == OP_PUSH);
  assign do_read  = io_valid && (opcode == OP_READ);
  assign coef_idx = io_rs2[2:0];
  assign rs1.re   = io_rs1_real;
  assign rs1.im   = io_rs1_imag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        coef[k] <= '0;
      end
    end else if (do_setc) begin
      for (int k = 0; k < NTAPS; k++) begin
        if (coef_idx == 3'(k)) begin
          coef[k] <= rs1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        samp[k] <= '0;
      end
    end else if (do_push) begin
      samp[0] <= rs1;
      for (int k = 1; k < NTAPS; k++) begin
        samp[k] <= samp[k-1];
      end
    end
  end

  for (genvar k = 0; k < NTAPS; k++) begin : g_tap
    scie_cmul u_cmul (
      .a (coef[k]),
      .b (samp[k]),
      .p (prod_next[k])
    );
  end

  // Products refresh every cycle, so a read sees the register state of one edge earlier.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NTAPS; k++) begin
        prod[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NTAPS; k++) begin
        prod[k] <= prod_next[k];
      end
    end
  end

  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int k = 0; k < NTAPS; k++) begin
      sum_re = sum_re + sext_prod(prod[k].re);
      sum_im = sum_im + sext_prod(prod[k].im);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_rd_real <= '0;
      io_rd_imag <= '0;
    end else if (do_read) begin
      io_rd_real <= sum_re[W-1:0];
      io_rd_imag <= sum_im[W-1:0];
    end
  end

endmodule

// File: tb/tb_scie_pipelined.sv
// tb/tb_scie_pipelined.sv - randomized self-checking bench for scie_pipelined
module tb_scie_pipelined;
  import scie_pkg::*;

  logic               clock = 1'b0;
  logic               reset;
  logic               io_valid;
  logic [31:0]        io_insn;
  logic signed [15:0] io_rs1_real;
  logic signed [15:0] io_rs1_imag;
  logic [31:0]        io_rs2;
  logic signed [15:0] io_rd_real;
  logic signed [15:0] io_rd_imag;

  int total = 0;
  int bad   = 0;

  int mc_re [5];
  int mc_im [5];
  int mx_re [5];
  int mx_im [5];
  logic signed [15:0] held_re, held_im;
  logic signed [15:0] exp_re, exp_im;

  scie_pipelined dut (
    .clock       (clock),
    .reset       (reset),
    .io_valid    (io_valid),
    .io_insn     (io_insn),
    .io_rs1_real (io_rs1_real),
    .io_rs1_imag (io_rs1_imag),
    .io_rs2      (io_rs2),
    .io_rd_real  (io_rd_real),
    .io_rd_imag  (io_rd_imag)
  );

  always #5 clock = ~clock;

  task automatic model_y(output logic signed [15:0] yr, output logic signed [15:0] yi);
    longint sr;
    longint si;
    sr = 0;
    si = 0;
    for (int k = 0; k < 5; k++) begin
      sr += longint'(mc_re[k]) * mx_re[k] - longint'(mc_im[k]) * mx_im[k];
      si += longint'(mc_re[k]) * mx_im[k] + longint'(mc_im[k]) * mx_re[k];
    end
    yr = sr[15:0];
    yi = si[15:0];
  endtask

  task automatic model_clear();
    for (int k = 0; k < 5; k++) begin
      mc_re[k] = 0; mc_im[k] = 0; mx_re[k] = 0; mx_im[k] = 0;
    end
    held_re = 0; held_im = 0; exp_re = 0; exp_im = 0;
  endtask

  // Drives one instruction for one edge and advances the reference model.
  // held_* is the filter value of the state seen before the previous edge.
  task automatic step(input logic v, input logic [6:0] op, input int re, input int im,
                      input logic [31:0] rs2);
    logic signed [15:0] yr, yi;
    logic [31:0] r;
    int idx;
    r = $urandom();
    io_valid    = v;
    io_insn     = {r[31:7], op};
    io_rs1_real = re[15:0];
    io_rs1_imag = im[15:0];
    io_rs2      = rs2;
    @(posedge clock);
    if (v && op == OP_READ) begin
      exp_re = held_re;
      exp_im = held_im;
    end
    model_y(yr, yi);
    held_re = yr;
    held_im = yi;
    idx = int'(rs2[2:0]);
    if (v && op == OP_SETC && idx < 5) begin
      mc_re[idx] = re;
      mc_im[idx] = im;
    end
    if (v && op == OP_PUSH) begin
      for (int k = 4; k > 0; k--) begin
        mx_re[k] = mx_re[k-1];
        mx_im[k] = mx_im[k-1];
      end
      mx_re[0] = re;
      mx_im[0] = im;
    end
    #1;
    io_valid = 1'b0;
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++;
    if (io_rd_real !== 16'sd0 || io_rd_imag !== 16'sd0) begin
      bad++;
      $display("FAIL reset_rd got=(%0d,%0d) want=(0,0)", io_rd_real, io_rd_imag);
    end
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    step(1'b1, OP_READ, 0, 0, 0);
    total++;
    if (io_rd_real !== 16'sd0 || io_rd_imag !== 16'sd0) begin
      bad++;
      $display("FAIL reset_read got=(%0d,%0d) want=(0,0)", io_rd_real, io_rd_imag);
    end
  endtask

  task automatic test_plan();
    int cre [5] = '{0, -29, -44, -25, -26};
    int cim [5] = '{-33, -32, -21, 40, 40};
    int pre [6] = '{-11, -36, -41, 27, -23, 6};
    int pim [6] = '{-44, -13, -31, -23, 22, -1};
    int wre [6] = '{-1452, -1518, -835, 2784, 3826, 3388};
    int wim [6] = '{363, 2816, 5049, 3308, 2376, -1622};
    logic signed [15:0] tr, ti;
    for (int k = 0; k < 5; k++) step(1'b1, OP_SETC, cre[k], cim[k], 32'(k));
    for (int i = 0; i < 6; i++) begin
      step(1'b1, OP_PUSH, pre[i], pim[i], 0);
      step(1'b0, OP_READ, 0, 0, 0);
      step(1'b1, OP_READ, 0, 0, 0);
      tr = wre[i][15:0];
      ti = wim[i][15:0];
      total++;
      if (io_rd_real !== tr || io_rd_imag !== ti) begin
        bad++;
        $display("FAIL plan_read%0d got=(%0d,%0d) want=(%0d,%0d)", i, io_rd_real, io_rd_imag, tr, ti);
      end
      total++;
      if (io_rd_real !== exp_re || io_rd_imag !== exp_im) begin
        bad++;
        $display("FAIL plan_model%0d got=(%0d,%0d) want=(%0d,%0d)", i, io_rd_real, io_rd_imag, exp_re, exp_im);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] before_re, before_im;
    before_re = held_re;
    before_im = held_im;
    step(1'b1, OP_PUSH, rnd16(), rnd16(), 0);
    step(1'b1, OP_READ, 0, 0, 0);
    total++;
    if (io_rd_real !== before_re || io_rd_imag !== before_im) begin
      bad++;
      $display("FAIL no_bubble_read got=(%0d,%0d) want=(%0d,%0d)", io_rd_real, io_rd_imag, before_re, before_im);
    end
    step(1'b0, OP_READ, 0, 0, 0);
    step(1'b1, OP_SETC, rnd16(), rnd16(), 32'd2);
    step(1'b1, OP_PUSH, rnd16(), rnd16(), 0);
    step(1'b1, 7'h33, rnd16(), rnd16(), 0);
    total++;
    if (io_rd_real !== exp_re || io_rd_imag !== exp_im) begin
      bad++;
      $display("FAIL rd_hold got=(%0d,%0d) want=(%0d,%0d)", io_rd_real, io_rd_imag, exp_re, exp_im);
    end
    step(1'b0, OP_READ, 0, 0, 0);
    step(1'b1, OP_READ, 0, 0, 0);
    total++;
    if (io_rd_real !== exp_re || io_rd_imag !== exp_im) begin
      bad++;
      $display("FAIL after_hold_read got=(%0d,%0d) want=(%0d,%0d)", io_rd_real, io_rd_imag, exp_re, exp_im);
    end
  endtask

  task automatic test_setc_ignored();
    logic signed [15:0] want_re, want_im;
    step(1'b0, OP_READ, 0, 0, 0);
    model_y(want_re, want_im);
    step(1'b1, OP_SETC, 1234, -4321, 32'd5);
    step(1'b1, OP_SETC, -777, 999, 32'hABCD_0007);
    step(1'b0, OP_READ, 0, 0, 0);
    step(1'b1, OP_READ, 0, 0, 0);
    total++;
    if (io_rd_real !== want_re || io_rd_imag !== want_im) begin
      bad++;
      $display("FAIL setc_idx_ignored got=(%0d,%0d) want=(%0d,%0d)", io_rd_real, io_rd_imag, want_re, want_im);
    end
    step(1'b1, OP_SETC, 321, -123, 32'hFFFF_FFF9);
    step(1'b0, OP_READ, 0, 0, 0);
    step(1'b1, OP_READ, 0, 0, 0);
    total++;
    if (io_rd_real !== exp_re || io_rd_imag !== exp_im) begin
      bad++;
      $display("FAIL setc_high_bits got=(%0d,%0d) want=(%0d,%0d)", io_rd_real, io_rd_imag, exp_re, exp_im);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 5; k++) step(1'b1, OP_SETC, 32767, 32767, 32'(k));
    for (int k = 0; k < 5; k++) step(1'b1, OP_PUSH, 32767, 0, 0);
    step(1'b0, OP_READ, 0, 0, 0);
    step(1'b1, OP_READ, 0, 0, 0);
    total++;
    if (io_rd_real !== 16'sd5 || io_rd_imag !== 16'sd5) begin
      bad++;
      $display("FAIL overflow_wrap got=(%0d,%0d) want=(5,5)", io_rd_real, io_rd_imag);
    end
    for (int k = 0; k < 5; k++) step(1'b1, OP_SETC, -32768, -32768, 32'(k));
    for (int k = 0; k < 5; k++) step(1'b1, OP_PUSH, -32768, -32768, 0);
    step(1'b0, OP_READ, 0, 0, 0);
    step(1'b1, OP_READ, 0, 0, 0);
    total++;
    if (io_rd_real !== exp_re || io_rd_imag !== exp_im) begin
      bad++;
      $display("FAIL overflow_min got=(%0d,%0d) want=(%0d,%0d)", io_rd_real, io_rd_imag, exp_re, exp_im);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [4] = '{OP_SETC, OP_PUSH, OP_READ, 7'h7B};
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2)      step(1'b1, ops[0], rnd16(), rnd16(), $urandom());
      else if (sel < 5) step(1'b1, ops[1], rnd16(), rnd16(), $urandom());
      else if (sel < 8) step(1'b1, ops[2], rnd16(), rnd16(), $urandom());
      else if (sel < 9) step(1'b1, ops[3], rnd16(), rnd16(), $urandom());
      else              step(1'b0, ops[2], rnd16(), rnd16(), $urandom());
      total++;
      if (io_rd_real !== exp_re || io_rd_imag !== exp_im) begin
        bad++;
        $display("FAIL random_step%0d got=(%0d,%0d) want=(%0d,%0d)", i, io_rd_real, io_rd_imag, exp_re, exp_im);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) step(1'b1, OP_SETC, rnd16(), rnd16(), 32'(k));
    for (int k = 0; k < 3; k++) step(1'b1, OP_PUSH, rnd16(), rnd16(), 0);
    step(1'b0, OP_READ, 0, 0, 0);
    step(1'b1, OP_READ, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (io_rd_real !== 16'sd0 || io_rd_imag !== 16'sd0) begin
      bad++;
      $display("FAIL async_reset_rd got=(%0d,%0d) want=(0,0)", io_rd_real, io_rd_imag);
    end
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    step(1'b0, OP_READ, 0, 0, 0);
    step(1'b1, OP_READ, 0, 0, 0);
    total++;
    if (io_rd_real !== 16'sd0 || io_rd_imag !== 16'sd0) begin
      bad++;
      $display("FAIL post_reset_read got=(%0d,%0d) want=(0,0)", io_rd_real, io_rd_imag);
    end
  endtask

  initial begin
    reset       = 1'b1;
    io_valid    = 1'b0;
    io_insn     = '0;
    io_rs1_real = '0;
    io_rs1_imag = '0;
    io_rs2      = '0;
    model_clear();
    test_reset();
    test_plan();
    test_back_to_back();
    test_setc_ignored();
    test_overflow();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scie_pipelined.md
# scie_pipelined

Pipelined complex-valued 5-tap FIR accelerator behind a SCIE-style custom-instruction port. The core issues custom-opcode instructions with one complex operand (`io_rs1_*`) and one scalar operand (`io_rs2`). Three instructions are supported: load a coefficient, push a sample, and read the filter output. The result is returned on `io_rd_*`.

## Interface
- `NTAPS`, 5: number of taps and coefficient registers.
- `W`, 16: width of each real/imaginary component, signed two's complement.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `io_valid` in 1: instruction valid this cycle.
- `io_insn` in 32: instruction word; only `io_insn[6:0]` (opcode) is decoded.
- `io_rs1_real` in W signed: operand 1, real part.
- `io_rs1_imag` in W signed: operand 1, imaginary part.
- `io_rs2` in 32: operand 2; coefficient index for the load-coefficient instruction.
- `io_rd_real` out W signed: result, real part; registered.
- `io_rd_imag` out W signed: result, imaginary part; registered.

## Operation
- Opcodes. Each takes effect only at a rising edge with `io_valid`=1.
  - `OP_SETC` = 7'h0B: coefficient `c[io_rs2[2:0]]` <= rs1. Indices 5–7 are ignored, and so are `io_rs2[31:3]`.
  - `OP_PUSH` = 7'h2B: delay line shifts, `x[k]` <= `x[k-1]` for k = 4..1, and `x[0]` <= rs1. The oldest sample is discarded.
  - `OP_READ` = 7'h5B: `rd` <= accumulated result (see Timing).
  - Any other opcode, or `io_valid`=0: no state change.
- Filter result: y = Σ_{k=0..4} `c[k]`·`x[k]`, using complex multiplication.
  - re = ar·br − ai·bi; im = ar·bi + ai·br.
  - Products are full 32-bit signed. The sum is kept at ≥35 bits internally.
  - The result is truncated to the low 16 bits (wrap-around, no saturation, no rounding).
- `OP_SETC` does not disturb the delay line, and `OP_PUSH` does not disturb the coefficients.
- After reset, all coefficients and samples are 0, so y = 0.
- `rd` holds its value in every cycle that is not a valid `OP_READ`.

## Timing
- Stage 1 runs every cycle: `prod[k]` <= `c[k]`·`x[k]`, computed from the register values before the edge.
- Stage 2 runs on a valid `OP_READ` edge: `rd` <= trunc16(Σ `prod[k]`).
- Push-to-read rule:
  - A push at edge E0 is reflected in a read at edge E2 or later.
  - A read at E1, immediately after a push, returns the result for the pre-push state.
  - Software therefore inserts ≥1 bubble between a push or coefficient write and the read. This is the required behaviour, not an error.
- `rd` is visible one edge after the `OP_READ` edge's inputs are sampled, i.e. directly after that edge.
- Reset values: `io_rd_real` = `io_rd_imag` = 0; all `c`, `x` and `prod` = 0.
- Reset asserted mid-sequence clears everything immediately; a subsequent read (after one bubble) returns 0.

## Structure
- Shared package `scie_pkg`:
  - Opcode constants `OP_SETC`, `OP_PUSH`, `OP_READ`.
  - `NTAPS`.
  - Typedef `cplx_t` (packed struct: signed [15:0] real, imag).
  - Typedef `cprod_t` (signed [31:0] real, imag).
- Sub-module `scie_cmul`: combinational complex multiply `cplx_t` × `cplx_t` -> `cprod_t`; instantiated NTAPS times.
- Top-level contents: decode, coefficient register file, delay line, product registers, adder tree, `rd` register.

## Test plan
- Load coefficients (`OP_SETC`, `io_rs2` = 0..4) = (0,−33), (−29,−32), (−44,−21), (−25,40), (−26,40). Push (−11,−44), one bubble, read -> `rd` = (−1452, 363).
- Continuing: push (−36,−13), bubble, read -> (−1518, 2816). Push (−41,−31), bubble, read -> (−835, 5049).
- Continuing pushes (27,−23), (−23,22), (6,−1) with read after each -> (2784, 3308), (3826, 2376), (3388, −1622).
  - This fills all 5 taps and evicts the oldest sample.
- Read issued directly after a push, with no bubble -> returns the previous result. `rd` is unchanged while `io_valid`=0 or the opcode is `OP_SETC`/`OP_PUSH`.
- `OP_SETC` with `io_rs2` = 5 or 7 -> no coefficient changes. Values chosen to overflow 16 bits (e.g. all taps (32767,32767) × (32767,0)) -> output equals the low 16 bits of the exact sum.
- Assert `reset` asynchronously mid-sequence -> `rd` goes to (0,0) at once; after release, bubble, read -> (0,0).
